fringe_get_reassembler: RTL and testbench
=========================================

Name: fringe_get_reassembler

Overview:
- Get-side receiver for the Fringe put/get handshake.
- Accepts one signal header, then the signal's stream of fixed-width payload words, as delivered by the TCP/SrcDst layer.
- Reassembles the words into one full-width signal value and presents it with FRNG_SIGNAL_VALID_GET or FRNG_SIGNAL_ERROR_GET status.
- Inverse of the put-side payload splitter; sits between the socket payload buffer and the signal DB update logic.

Parameters:
- N_BITS_PER_PAYLOAD, 64, width of one payload word (= FRNG_N_OF_BITS_PER_PAYLOAD)
- MAX_BITS_PER_SIGNAL, 1024, full signal width (= FRNG_MAX_N_OF_BITS_PER_SIGNAL)
- MAX_PAYLOADS, 16, maximum payload words per signal; must be ≥ MAX_BITS_PER_SIGNAL/N_BITS_PER_PAYLOAD

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hdr_valid  in  1  header offered
- hdr_ready  out  1  header accepted when hdr_valid&hdr_ready
- hdr_signal_id  in  64  signal identifier
- hdr_n_payloads  in  $clog2(MAX_PAYLOADS+1)  payload words that follow
- hdr_signal_size  in  32  signal size in bits
- hdr_signal_type  in  fringe_signal_type_e  data type
- pl_valid  in  1  payload word offered
- pl_ready  out  1  payload word accepted when pl_valid&pl_ready
- pl_data_bit  in  N_BITS_PER_PAYLOAD  2-state payload plane
- pl_data_logic  in  N_BITS_PER_PAYLOAD  4-state payload plane
- out_valid  out  1  reassembled signal available
- out_ready  in  1  consumer accepts
- out_signal_id  out  64  id of the held signal
- out_signal_type  out  fringe_signal_type_e  type of the held signal
- out_data_bit  out  MAX_BITS_PER_SIGNAL  reassembled 2-state value
- out_data_logic  out  MAX_BITS_PER_SIGNAL  reassembled 4-state value
- out_status  out  fringe_signal_hs_e  FRNG_SIGNAL_VALID_GET or FRNG_SIGNAL_ERROR_GET
- event_cnt  out  64  count of completed output handshakes

Behaviour:
- Reset values:
  - All outputs 0.
  - out_status = FRNG_SIGNAL_IDLE.
  - State = S_IDLE.
  - Payload index = 0.
- Reset mid-packet discards the partial signal. No output is produced for it.
- State machine:
  - S_IDLE: hdr_ready=1, pl_ready=0. On a header handshake, latch id, type, size and n_payloads. Clear both data accumulators to 0.
    - Header invalid → S_DRAIN. Invalid means: n_payloads==0, n_payloads>MAX_PAYLOADS, size==0, size>MAX_BITS_PER_SIGNAL, or size>n_payloads*N_BITS_PER_PAYLOAD.
    - Header valid → S_COLLECT.
  - S_COLLECT: pl_ready=1, hdr_ready=0.
    - Each accepted word k is written to bits [k*N_BITS_PER_PAYLOAD +: N_BITS_PER_PAYLOAD]. Word 0 is the LSB word.
    - Index increments per accepted word.
    - After word n_payloads-1: go to S_OUT with out_status=VALID_GET.
  - S_DRAIN: pl_ready=1. Accept and discard n_payloads words (0 words if n_payloads==0), then go to S_OUT with out_status=ERROR_GET and data 0.
    - n_payloads>MAX_PAYLOADS still drains all n_payloads words.
  - S_OUT: out_valid=1, and outputs are held stable until out_ready.
    - On the handshake: event_cnt += 1 (wraps at 2^64), out_status → IDLE, state → S_IDLE.
    - Error results also count.
- Masking: bits at or above signal_size are forced to 0 in both planes on output.
- Latency: out_valid rises the cycle after the last payload handshake. Minimum packet time is n_payloads+2 cycles with the source and sink always ready.
- Word writes beyond MAX_BITS_PER_SIGNAL are discarded. This is unreachable once headers are validated.
- No simultaneous header and payload acceptance: ready signals are mutually exclusive by state.
- Payload words offered in S_IDLE or S_OUT are back-pressured, never dropped.

Optional Feature:
- Macro: FRNG_REASM_LOGIC_EN.
- Defined: the pl_data_logic plane is accumulated and driven on out_data_logic.
- Undefined:
  - The logic accumulator is not built.
  - out_data_logic is a 2-state copy of the masked out_data_bit.
  - pl_data_logic is ignored.

Decomposition:
- Package shunt_fringe_pkg holds: fringe_signal_type_e, fringe_signal_hs_e, data_in_t, signal_db_data_in_t, and the width macros.
- Add to it: a reassembler state enum (S_IDLE, S_COLLECT, S_DRAIN, S_OUT) and a header struct {signal_id, n_payloads, signal_size, signal_type}.
- One natural sub-module: fringe_payload_accum. It is the indexed word writer plus size mask, instantiated once per data plane.

Test Plan:
- Header id=0x5, n=2, size=100, type=SHUNT_BIT, then words 0xA..A and 0x3 → out_valid after 4 cycles; out_data_bit[63:0]=0xAAAA_AAAA_AAAA_AAAA, bits[99:64]=0x3, bits ≥100 =0; VALID_GET; event_cnt=1.
- Full width n=16, size=1024, pl_valid toggling every other cycle → all 16 words placed in order; no word lost or duplicated.
- Header n=2, size=200 → 2 words drained; ERROR_GET with data 0; next valid packet reassembles correctly.
- out_ready held 0 for 10 cycles after out_valid → outputs stable; hdr_ready=0 and pl_ready=0 throughout.
- rst asserted after word 1 of 3 → all outputs 0 immediately; a following packet completes correctly with event_cnt=1.
- With FRNG_REASM_LOGIC_EN, an X/Z pattern on pl_data_logic is reproduced on out_data_logic. Without it, out_data_logic == out_data_bit.

Source files
------------

// File: rtl/shunt_fringe_pkg.sv
// Shared Fringe put/get types and widths, plus the get-side reassembler state and header types.
`ifndef FRNG_N_OF_BITS_PER_PAYLOAD
`define FRNG_N_OF_BITS_PER_PAYLOAD 64
`endif
`ifndef FRNG_MAX_N_OF_BITS_PER_SIGNAL
`define FRNG_MAX_N_OF_BITS_PER_SIGNAL 1024
`endif
`ifndef FRNG_MAX_N_OF_PAYLOADS
`define FRNG_MAX_N_OF_PAYLOADS 16
`endif

package shunt_fringe_pkg;

   localparam int unsigned FRNG_N_OF_BITS_PER_PAYLOAD    = `FRNG_N_OF_BITS_PER_PAYLOAD;
   localparam int unsigned FRNG_MAX_N_OF_BITS_PER_SIGNAL = `FRNG_MAX_N_OF_BITS_PER_SIGNAL;
   localparam int unsigned FRNG_MAX_N_OF_PAYLOADS        = `FRNG_MAX_N_OF_PAYLOADS;

   typedef enum logic [3:0] {
      SHUNT_INT         = 4'd0,
      SHUNT_REAL        = 4'd1,
      SHUNT_SHORTREAL   = 4'd2,
      SHUNT_STRING      = 4'd3,
      SHUNT_A_STRUCTURE = 4'd4,
      SHUNT_BYTE        = 4'd5,
      SHUNT_BIT         = 4'd6,
      SHUNT_REG         = 4'd7,
      SHUNT_LOGIC       = 4'd8,
      SHUNT_HEADER_ONLY = 4'd9
   } fringe_signal_type_e;

   typedef enum logic [2:0] {
      FRNG_SIGNAL_IDLE      = 3'd0,
      FRNG_SIGNAL_ANY_GET   = 3'd1,
      FRNG_SIGNAL_VALID_GET = 3'd2,
      FRNG_SIGNAL_ERROR_GET = 3'd3,
      FRNG_SIGNAL_PUT       = 3'd4
   } fringe_signal_hs_e;

   typedef struct packed {
      logic [FRNG_MAX_N_OF_BITS_PER_SIGNAL-1:0] data_bit;
      logic [FRNG_MAX_N_OF_BITS_PER_SIGNAL-1:0] data_logic;
   } data_in_t;

   typedef struct packed {
      logic [63:0]         signal_id;
      fringe_signal_type_e signal_type;
      logic [31:0]         signal_size;
      data_in_t            data;
   } signal_db_data_in_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2,
      S_OUT     = 2'd3
   } reasm_state_e;

   typedef struct packed {
      logic [63:0]         signal_id;
      logic [15:0]         n_payloads;
      logic [31:0]         signal_size;
      fringe_signal_type_e signal_type;
   } reasm_hdr_t;

endpackage

// File: rtl/fringe_get_reassembler_accum.sv
// Indexed payload-word writer for one data plane, with output masked above signal size.
module fringe_payload_accum #(
   parameter int unsigned N_BITS_PER_PAYLOAD  = 64,
   parameter int unsigned MAX_BITS_PER_SIGNAL = 1024,
   parameter int unsigned IDX_W               = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           wr_en,
   input  logic [IDX_W-1:0]               wr_idx,
   input  logic [N_BITS_PER_PAYLOAD-1:0]  wr_data,
   input  logic [31:0]                    size,
   output logic [MAX_BITS_PER_SIGNAL-1:0] data
);

   localparam int unsigned N_WORDS = (MAX_BITS_PER_SIGNAL + N_BITS_PER_PAYLOAD - 1) / N_BITS_PER_PAYLOAD;

   logic [MAX_BITS_PER_SIGNAL-1:0] acc;

   // Indices past the last slot match no word, so such writes fall away.
   for (genvar k = 0; k < N_WORDS; k++) begin : g_word
      localparam int unsigned LO = k * N_BITS_PER_PAYLOAD;
      localparam int unsigned W  = (LO + N_BITS_PER_PAYLOAD > MAX_BITS_PER_SIGNAL) ?
                                   MAX_BITS_PER_SIGNAL - LO : N_BITS_PER_PAYLOAD;
      logic [W-1:0] q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            q <= '0;
         else if (clear)
            q <= '0;
         else if (wr_en && (32'(wr_idx) == k))
            q <= wr_data[W-1:0];
      end

      assign acc[LO +: W] = q;
   end

   assign data = acc & ~({MAX_BITS_PER_SIGNAL{1'b1}} << size);

endmodule

// File: rtl/fringe_get_reassembler.sv
// Fringe get-side receiver: header + payload words in, one reassembled signal out.
// FRNG_REASM_LOGIC_EN builds the 4-state accumulator; otherwise out_data_logic mirrors out_data_bit.
module fringe_get_reassembler
   import shunt_fringe_pkg::*;
#(
   parameter int unsigned N_BITS_PER_PAYLOAD  = 64,
   parameter int unsigned MAX_BITS_PER_SIGNAL = 1024,
   parameter int unsigned MAX_PAYLOADS        = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 hdr_valid,
   output logic                                 hdr_ready,
   input  logic [63:0]                          hdr_signal_id,
   input  logic [$clog2(MAX_PAYLOADS+1)-1:0]    hdr_n_payloads,
   input  logic [31:0]                          hdr_signal_size,
   input  fringe_signal_type_e                  hdr_signal_type,
   input  logic                                 pl_valid,
   output logic                                 pl_ready,
   input  logic [N_BITS_PER_PAYLOAD-1:0]        pl_data_bit,
   input  logic [N_BITS_PER_PAYLOAD-1:0]        pl_data_logic,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [63:0]                          out_signal_id,
   output fringe_signal_type_e                  out_signal_type,
   output logic [MAX_BITS_PER_SIGNAL-1:0]       out_data_bit,
   output logic [MAX_BITS_PER_SIGNAL-1:0]       out_data_logic,
   output fringe_signal_hs_e                    out_status,
   output logic [63:0]                          event_cnt
);

   localparam int unsigned NPW = $clog2(MAX_PAYLOADS + 1);

   reasm_state_e state_q, state_d;
   reasm_hdr_t   hdr_q;
   logic [NPW-1:0] idx_q;
   logic hdr_bad, last_word, hdr_fire, pl_fire, out_fire, wr_en;
   logic [63:0] hdr_capacity;

   assign hdr_capacity = 64'(hdr_n_payloads) * 64'(N_BITS_PER_PAYLOAD);
   assign hdr_bad = (hdr_n_payloads == '0) ||
                    (32'(hdr_n_payloads) > MAX_PAYLOADS) ||
                    (hdr_signal_size == '0) ||
                    (hdr_signal_size > MAX_BITS_PER_SIGNAL) ||
                    (64'(hdr_signal_size) > hdr_capacity);
   assign last_word = (16'(idx_q) == hdr_q.n_payloads - 16'd1);

   assign hdr_fire = hdr_valid && hdr_ready;
   assign pl_fire  = pl_valid && pl_ready;
   assign out_fire = out_valid && out_ready;
   assign wr_en    = pl_fire && (state_q == S_COLLECT);

   always_comb begin
      state_d   = state_q;
      hdr_ready = 1'b0;
      pl_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            hdr_ready = 1'b1;
            if (hdr_valid)
               state_d = hdr_bad ? S_DRAIN : S_COLLECT;
         end
         S_COLLECT: begin
            pl_ready = 1'b1;
            if (pl_valid && last_word)
               state_d = S_OUT;
         end
         S_DRAIN: begin
            // A zero-length bad header has nothing to drain; do not swallow the next packet's word.
            if (hdr_q.n_payloads == '0)
               state_d = S_OUT;
            else begin
               pl_ready = 1'b1;
               if (pl_valid && last_word)
                  state_d = S_OUT;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hdr_q      <= '0;
         idx_q      <= '0;
         out_status <= FRNG_SIGNAL_IDLE;
         event_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (hdr_fire) begin
            hdr_q.signal_id   <= hdr_signal_id;
            hdr_q.n_payloads  <= 16'(hdr_n_payloads);
            hdr_q.signal_size <= hdr_signal_size;
            hdr_q.signal_type <= hdr_signal_type;
            idx_q             <= '0;
         end
         if (pl_fire)
            idx_q <= idx_q + 1'b1;
         if ((state_q != S_OUT) && (state_d == S_OUT))
            out_status <= (state_q == S_COLLECT) ? FRNG_SIGNAL_VALID_GET : FRNG_SIGNAL_ERROR_GET;
         if (out_fire) begin
            event_cnt  <= event_cnt + 64'd1;
            out_status <= FRNG_SIGNAL_IDLE;
         end
      end
   end

   assign out_signal_id   = hdr_q.signal_id;
   assign out_signal_type = hdr_q.signal_type;

   fringe_payload_accum #(
      .N_BITS_PER_PAYLOAD  (N_BITS_PER_PAYLOAD),
      .MAX_BITS_PER_SIGNAL (MAX_BITS_PER_SIGNAL),
      .IDX_W               (NPW)
   ) u_accum_bit (
      .clk     (clk),
      .rst     (rst),
      .clear   (hdr_fire),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (pl_data_bit),
      .size    (hdr_q.signal_size),
      .data    (out_data_bit)
   );

`ifdef FRNG_REASM_LOGIC_EN
   fringe_payload_accum #(
      .N_BITS_PER_PAYLOAD  (N_BITS_PER_PAYLOAD),
      .MAX_BITS_PER_SIGNAL (MAX_BITS_PER_SIGNAL),
      .IDX_W               (NPW)
   ) u_accum_logic (
      .clk     (clk),
      .rst     (rst),
      .clear   (hdr_fire),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (pl_data_logic),
      .size    (hdr_q.signal_size),
      .data    (out_data_logic)
   );
`else
   logic unused_logic_plane;
   assign unused_logic_plane = ^pl_data_logic;
   assign out_data_logic     = out_data_bit;
`endif

endmodule

// File: tb/tb_fringe_get_reassembler.sv
// Scoreboard bench for fringe_get_reassembler: directed packets, monitor compares each output handshake.
module tb_fringe_get_reassembler;
   import shunt_fringe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic hdr_valid, hdr_ready;
   logic [63:0] hdr_signal_id;
   logic [4:0] hdr_n_payloads;
   logic [31:0] hdr_signal_size;
   fringe_signal_type_e hdr_signal_type;
   logic pl_valid, pl_ready;
   logic [63:0] pl_data_bit, pl_data_logic;
   logic out_valid, out_ready;
   logic [63:0] out_signal_id;
   fringe_signal_type_e out_signal_type;
   logic [1023:0] out_data_bit, out_data_logic;
   fringe_signal_hs_e out_status;
   logic [63:0] event_cnt;

   always #5 clk = ~clk;

   fringe_get_reassembler #(
      .N_BITS_PER_PAYLOAD  (64),
      .MAX_BITS_PER_SIGNAL (1024),
      .MAX_PAYLOADS        (16)
   ) dut (
      .clk(clk), .rst(rst),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_signal_id(hdr_signal_id),
      .hdr_n_payloads(hdr_n_payloads), .hdr_signal_size(hdr_signal_size),
      .hdr_signal_type(hdr_signal_type),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data_bit(pl_data_bit),
      .pl_data_logic(pl_data_logic),
      .out_valid(out_valid), .out_ready(out_ready), .out_signal_id(out_signal_id),
      .out_signal_type(out_signal_type), .out_data_bit(out_data_bit),
      .out_data_logic(out_data_logic), .out_status(out_status), .event_cnt(event_cnt)
   );

   typedef struct {
      logic [63:0]         id;
      fringe_signal_type_e typ;
      fringe_signal_hs_e   st;
      logic [1023:0]       db;
      logic [1023:0]       dl;
      logic [63:0]         evt;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] evt_model = 0;
   logic [63:0] wq [32];

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            timeout("unexpected_output");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_signal_id", out_signal_id, e.id);
            chk("out_signal_type", out_signal_type, e.typ);
            chk("out_status", out_status, e.st);
            chk("out_data_bit", out_data_bit, e.db);
            chk("out_data_logic", out_data_logic, e.dl);
            chk("event_cnt", event_cnt, e.evt);
         end
      end
   end

   task automatic send_hdr(input logic [63:0] id, input int n, input int size, input fringe_signal_type_e t);
      hdr_signal_id = id;
      hdr_n_payloads = 5'(n);
      hdr_signal_size = 32'(size);
      hdr_signal_type = t;
      hdr_valid = 1'b1;
      for (int c = 0; c <= 200; c++) begin
         @(negedge clk);
         if (hdr_ready) break;
         if (c == 200) timeout("hdr_ready");
      end
      @(posedge clk); #1;
      hdr_valid = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] w, input int gap);
      pl_data_bit = w;
      pl_data_logic = ~w;
      pl_valid = 1'b1;
      for (int c = 0; c <= 200; c++) begin
         @(negedge clk);
         if (pl_ready) break;
         if (c == 200) timeout("pl_ready");
      end
      @(posedge clk); #1;
      pl_valid = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   // Expected value is pushed before stimulus; err is the hand-derived header verdict.
   task automatic run_packet(input logic [63:0] id, input int n, input int size,
                             input fringe_signal_type_e t, input bit err, input bit toggle);
      exp_t e;
      e.id = id; e.typ = t; e.evt = evt_model;
      e.st = err ? FRNG_SIGNAL_ERROR_GET : FRNG_SIGNAL_VALID_GET;
      e.db = '0; e.dl = '0;
      if (!err) begin
         for (int k = 0; k < n; k++) begin
            e.db[k*64 +: 64] = wq[k];
            e.dl[k*64 +: 64] = ~wq[k];
         end
         for (int b = 0; b < 1024; b++) begin
            if (b >= size) begin
               e.db[b] = 1'b0;
               e.dl[b] = 1'b0;
            end
         end
      end
`ifndef FRNG_REASM_LOGIC_EN
      e.dl = e.db;
`endif
      sb.push_back(e);
      evt_model++;
      send_hdr(id, n, size, t);
      for (int k = 0; k < n; k++) send_word(wq[k], toggle ? (k % 2) : 0);
   endtask

   task automatic wait_empty(input string name);
      for (int c = 0; c <= 500; c++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
         if (c == 500) timeout(name);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      hdr_valid = 1'b0; hdr_signal_id = '0; hdr_n_payloads = '0; hdr_signal_size = '0;
      hdr_signal_type = SHUNT_INT;
      pl_valid = 1'b0; pl_data_bit = '0; pl_data_logic = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_status", out_status, FRNG_SIGNAL_IDLE);
      chk("rst_event_cnt", event_cnt, 64'd0);
      chk("rst_out_data_bit", out_data_bit, '0);
      chk("rst_pl_ready", pl_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic packet plus latency: out_valid in the cycle after the last word.
      wq[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      wq[1] = 64'h3;
      run_packet(64'h5, 2, 100, SHUNT_BIT, 1'b0, 1'b0);
      @(negedge clk);
      chk("latency_out_valid", out_valid, 1'b1);
      wait_empty("basic_drain");
      chk("event_cnt_after_basic", event_cnt, 64'd1);

      // Masking of a partially used final word.
      for (int k = 0; k < 3; k++) wq[k] = '1;
      run_packet(64'h77, 3, 130, SHUNT_LOGIC, 1'b0, 1'b0);

      // Full width, valid toggling.
      for (int k = 0; k < 16; k++) wq[k] = {32'hC0DE_0000 | 32'(k), 32'(k * 3 + 1)};
      run_packet(64'hF00D, 16, 1024, SHUNT_REG, 1'b0, 1'b1);

      // Oversize header drains, then a good packet follows.
      wq[0] = 64'hDEAD_BEEF_0000_0001; wq[1] = 64'h1;
      run_packet(64'hBAD1, 2, 200, SHUNT_BIT, 1'b1, 1'b0);
      wq[0] = 64'h1234;
      run_packet(64'h9, 1, 64, SHUNT_INT, 1'b0, 1'b0);

      // Zero payloads, too many payloads, zero size.
      run_packet(64'hBAD2, 0, 8, SHUNT_BYTE, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++) wq[k] = 64'(k + 100);
      run_packet(64'hBAD3, 20, 64, SHUNT_BYTE, 1'b1, 1'b0);
      wq[0] = 64'h55;
      run_packet(64'hBAD4, 1, 0, SHUNT_BYTE, 1'b1, 1'b0);
      wait_empty("errors_drain");

      // Consumer stall: outputs held, both inputs back-pressured.
      out_ready = 1'b0;
      wq[0] = 64'hFFFF;
      run_packet(64'h42, 1, 8, SHUNT_BYTE, 1'b0, 1'b0);
      for (int c = 0; c <= 50; c++) begin
         @(negedge clk);
         if (out_valid) break;
         if (c == 50) timeout("stall_out_valid");
      end
      for (int c = 0; c < 10; c++) begin
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_out_data_bit", out_data_bit, sb[0].db);
         chk("stall_hdr_ready", hdr_ready, 1'b0);
         chk("stall_pl_ready", pl_ready, 1'b0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty("stall_drain");

      // Reset part way through a three-word packet.
      send_hdr(64'hABC, 3, 192, SHUNT_BIT);
      send_word(64'h1111, 0);
      send_word(64'h2222, 0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_event_cnt", event_cnt, 64'd0);
      chk("midrst_out_status", out_status, FRNG_SIGNAL_IDLE);
      chk("midrst_out_data_bit", out_data_bit, '0);
      chk("midrst_out_signal_id", out_signal_id, 64'd0);
      chk("midrst_pl_ready", pl_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      evt_model = 0;
      wq[0] = 64'h0123_4567_89AB_CDEF; wq[1] = 64'hFEDC_BA98_7654_3210; wq[2] = 64'h0F0F;
      run_packet(64'hCAFE, 3, 140, SHUNT_LOGIC, 1'b0, 1'b0);
      wait_empty("final_drain");
      chk("event_cnt_after_rst", event_cnt, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
